// File: rtl/seg_pkg.sv
// Shared constants for the segment scan controller: hex-to-segment table,
// blank word and the segment bus layout.
package seg_pkg;

  localparam int unsigned HEX_W  = 4;
  localparam int unsigned PAT_W  = 7;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned HEX_NUM = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Segment bus word: dp_n is SEG[7], pattern is {g,f,e,d,c,b,a}, all active-low
  typedef struct packed {
    logic             dp_n;
    logic [PAT_W-1:0] pattern;
  } seg_word_t;

  // Entry k is the active-low pattern of hex digit k (listed F down to 0)
  localparam logic [HEX_NUM-1:0][PAT_W-1:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic seg_word_t make_seg_word(input logic dp_on, input logic [PAT_W-1:0] pat);
    seg_word_t w;
    w.dp_n    = ~dp_on;
    w.pattern = pat;
    return w;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to active-low 7-segment pattern (combinational table lookup).
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [HEX_W-1:0] nibble,
  output logic [PAT_W-1:0] pattern_c
);

  assign pattern_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-digit dwell, PWM dimming and
// frame-synchronous shadow loading. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned PWM_BITS   = 3
) (
  input  logic                      led_clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [PWM_BITS-1:0]       brightness,
  input  logic                      load,
  output logic                      frame_start,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [SEG_W-1:0]          SEG
);

  localparam int unsigned SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef logic [NUM_DIGITS-1:0][HEX_W-1:0] nib_vec_t;

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DW_W-1:0]       dwell_q, dwell_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic                  pending_q, pending_d;
  nib_vec_t              sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] an_d;
  seg_word_t             seg_d;

  logic                  last_dwell, last_digit, boundary, lit;
  logic [HEX_W-1:0]      cur_nibble;
  logic [PAT_W-1:0]      cur_pattern;
  logic [NUM_DIGITS-1:0] blank;

  // Decoded from state so the first frame after reset is flagged as well
  assign frame_start = !rst && (sel_q == '0) && (dwell_q == '0);

  assign last_dwell = (dwell_q == DW_W'(DWELL - 1));
  assign last_digit = (sel_q == SEL_W'(NUM_DIGITS - 1));
  assign boundary   = last_dwell && last_digit;

`ifdef SEG_SCAN_LZB_EN
  logic lzb_lead;

  // Blank zero nibbles from the top digit down until a nonzero nibble or a dp
  always_comb begin
    blank    = '0;
    lzb_lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if ((act_data_q[i] != '0) || act_dp_q[i]) lzb_lead = 1'b0;
      blank[i] = lzb_lead;
    end
  end
`else
  assign blank = '0;
`endif

  assign cur_nibble = act_data_q[sel_q];

  seg_hex_decoder u_hex_decoder (
    .nibble    (cur_nibble),
    .pattern_c (cur_pattern)
  );

  // Next-state: scan counters, shadow/active handoff and registered drive
  always_comb begin
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    pwm_d      = pwm_q + PWM_BITS'(1);
    pending_d  = pending_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    lit        = 1'b0;
    an_d       = '1;
    seg_d      = seg_word_t'(SEG_BLANK);

    if (last_dwell) begin
      dwell_d = '0;
      sel_d   = last_digit ? '0 : sel_q + SEL_W'(1);
    end else begin
      dwell_d = dwell_q + DW_W'(1);
    end

    // A load on the boundary cycle bypasses the shadow so no frame shows stale data
    if (load) begin
      sh_data_d = data;
      sh_dp_d   = dp;
      sh_en_d   = digit_en;
      if (boundary) begin
        act_data_d = data;
        act_dp_d   = dp;
        act_en_d   = digit_en;
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (boundary && pending_q) begin
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
      act_en_d   = sh_en_q;
      pending_d  = 1'b0;
    end

    lit = act_en_q[sel_q] && !blank[sel_q] && (pwm_q < brightness);
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << sel_q);
      seg_d = make_seg_word(act_dp_q[sel_q], cur_pattern);
    end
  end

  always_ff @(posedge led_clk) begin
    if (rst) begin
      sel_q      <= '0;
      dwell_q    <= '0;
      pwm_q      <= '0;
      pending_q  <= 1'b0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      AN         <= '1;
      SEG        <= SEG_BLANK;
    end else begin
      sel_q      <= sel_d;
      dwell_q    <= dwell_d;
      pwm_q      <= pwm_d;
      pending_q  <= pending_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      AN         <= an_d;
      SEG        <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, directed corner sequences
// and randomized stimulus against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned P  = 3;
  localparam int unsigned ND = N * D;

  logic           led_clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [4*N-1:0] data = '0;
  logic [N-1:0]   dp = '0;
  logic [N-1:0]   digit_en = '0;
  logic [P-1:0]   brightness = '0;
  logic           frame_start;
  logic [N-1:0]   AN;
  logic [7:0]     SEG;

  always #5 led_clk = ~led_clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .PWM_BITS(P)) dut (
    .led_clk     (led_clk),
    .rst         (rst),
    .data        (data),
    .dp          (dp),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .load        (load),
    .frame_start (frame_start),
    .AN          (AN),
    .SEG         (SEG)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [7:0] seg;
  } vec_t;

  vec_t vecs [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in the scan is derived from cycles since reset
  int             m_c = 0;
  logic           m_pend = 1'b0;
  logic [4*N-1:0] m_sh_data = '0, m_act_data = '0;
  logic [N-1:0]   m_sh_dp = '0, m_act_dp = '0, m_sh_en = '0, m_act_en = '0;
  logic [N-1:0]   e_an = '1;
  logic [7:0]     e_seg = 8'hFF;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] blank_mask(input logic [4*N-1:0] d, input logic [N-1:0] p);
    logic [N-1:0] m;
    m = '0;
`ifdef SEG_SCAN_LZB_EN
    for (int i = N - 1; i > 0; i--) begin
      if (d[4*i +: 4] != 4'h0 || p[i]) break;
      m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic model_edge();
    int s, pw;
    logic [N-1:0] bl;
    logic [3:0] nib;
    logic bnd;
    if (rst) begin
      m_c = 0; m_pend = 1'b0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_en = '0;
      m_act_data = '0; m_act_dp = '0; m_act_en = '0;
      e_an = '1; e_seg = 8'hFF;
    end else begin
      s   = (m_c / D) % N;
      pw  = m_c % (1 << P);
      bl  = blank_mask(m_act_data, m_act_dp);
      nib = m_act_data[4*s +: 4];
      if (m_act_en[s] && !bl[s] && pw < brightness) begin
        e_an  = ~(8'd1 << s);
        e_seg = {~m_act_dp[s], vecs[nib].seg[6:0]};
      end else begin
        e_an  = '1;
        e_seg = 8'hFF;
      end
      bnd = ((m_c % ND) == ND - 1);
      if (load) begin
        m_sh_data = data; m_sh_dp = dp; m_sh_en = digit_en;
        if (bnd) begin
          m_act_data = data; m_act_dp = dp; m_act_en = digit_en; m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (bnd && m_pend) begin
        m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_en = m_sh_en; m_pend = 1'b0;
      end
      m_c++;
    end
  endtask

  task automatic tick();
    @(posedge led_clk);
    model_edge();
    @(negedge led_clk);
    check("an", AN, e_an);
    check("seg", SEG, e_seg);
    check("frame_start", frame_start, (!rst && (m_c % ND) == 0));
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 2 * ND);
    if (!frame_start) check("frame_start_seen", frame_start, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt [N];
    int bad, seen, nseen, nbad, c0, c1, c2;

    vecs[0]  = '{4'h0, 8'hC0}; vecs[1]  = '{4'h1, 8'hF9};
    vecs[2]  = '{4'h2, 8'hA4}; vecs[3]  = '{4'h3, 8'hB0};
    vecs[4]  = '{4'h4, 8'h99}; vecs[5]  = '{4'h5, 8'h92};
    vecs[6]  = '{4'h6, 8'h82}; vecs[7]  = '{4'h7, 8'hF8};
    vecs[8]  = '{4'h8, 8'h80}; vecs[9]  = '{4'h9, 8'h90};
    vecs[10] = '{4'hA, 8'h88}; vecs[11] = '{4'hB, 8'h83};
    vecs[12] = '{4'hC, 8'hC6}; vecs[13] = '{4'hD, 8'hA1};
    vecs[14] = '{4'hE, 8'h86}; vecs[15] = '{4'hF, 8'h8E};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_an", AN, 8'hFF);
    check("rst_seg", SEG, 8'hFF);
    check("rst_fs", frame_start, 0);
    rst = 1'b0;

    // Full-brightness scan order and per-digit dwell
    brightness = 3'd7; digit_en = 8'hFF; dp = 8'h00; data = 32'h76543210;
    load = 1'b1; tick(); load = 1'b0;
    wait_frame();
    bad = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    repeat (2 * ND) begin
      tick();
      for (int i = 0; i < N; i++)
        if (AN == ~(8'd1 << i)) begin
          cnt[i]++;
          if (SEG != vecs[i].seg) bad++;
        end
    end
    for (int i = 0; i < N; i++) check($sformatf("dwell_d%0d", i), cnt[i], (i % 2) ? 6 : 8);
    check("order_seg", bad, 0);

    // Decoder table through the whole datapath
    for (int v = 0; v < 16; v++) begin
      data = {8{vecs[v].nib}};
      load = 1'b1; tick(); load = 1'b0;
      wait_frame();
      tick();
      check("tbl_an", AN, 8'hFE);
      check($sformatf("tbl_seg_%0h", v), SEG, vecs[v].seg);
    end

    // Mid-frame load holds off until the next frame
    data = 32'h76543210; load = 1'b1; tick(); load = 1'b0;
    wait_frame();
    repeat (12) tick();
    data = 32'h11111111; load = 1'b1; tick(); load = 1'b0;
    bad = 0; seen = 0;
    for (int k = 0; k < 2 * ND; k++) begin
      tick();
      if (frame_start) break;
      for (int i = 0; i < N; i++)
        if (AN == ~(8'd1 << i)) begin
          if (i >= 4) seen++;
          if (SEG != vecs[i].seg) bad++;
        end
    end
    check("tear_old_seg", bad, 0);
    check("tear_old_seen", seen, 14);
    nbad = 0; nseen = 0;
    repeat (ND) begin
      tick();
      if (AN != 8'hFF) begin
        nseen++;
        if (SEG != 8'hF9) nbad++;
      end
    end
    check("tear_new_seg", nbad, 0);
    check("tear_new_seen", nseen, 28);

    // Brightness extremes
    brightness = 3'd0; seen = 0;
    repeat (2 * ND) begin tick(); if (AN != 8'hFF) seen++; end
    check("bright0_lit", seen, 0);
    brightness = 3'd4; seen = 0;
    repeat (2 * ND) begin tick(); if (AN != 8'hFF) seen++; end
    check("bright4_lit", seen, 32);

    // Disabled upper digits and a single decimal point
    brightness = 3'd7; digit_en = 8'h0F; dp = 8'h01;
    load = 1'b1; tick(); load = 1'b0;
    wait_frame();
    c0 = 0; c1 = 0; c2 = 0; seen = 0;
    repeat (2 * ND) begin
      tick();
      if (AN[7:4] != 4'hF) c0++;
      if (AN != 8'hFF) seen++;
      if (AN == 8'hFE && !SEG[7]) c1++;
      if (AN != 8'hFE && AN != 8'hFF && !SEG[7]) c2++;
    end
    check("en_hi_low", c0, 0);
    check("en_lit", seen, 28);
    check("dp_d0", c1, 8);
    check("dp_other", c2, 0);

`ifdef SEG_SCAN_LZB_EN
    // Leading-zero blanking
    digit_en = 8'hFF; dp = 8'h00; data = 32'h00000120;
    load = 1'b1; tick(); load = 1'b0;
    wait_frame();
    c0 = 0; bad = 0; seen = 0;
    repeat (2 * ND) begin
      tick();
      if (AN[7:3] != 5'h1F) c0++;
      if (AN == 8'hFB) begin seen++; if (SEG != 8'hF9) bad++; end
      if (AN == 8'hFD && SEG != 8'hA4) bad++;
      if (AN == 8'hFE && SEG != 8'hC0) bad++;
    end
    check("lzb_hi_low", c0, 0);
    check("lzb_seg", bad, 0);
    check("lzb_d2_seen", seen, 8);
`endif

    // Randomized stimulus against the model
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        data       = $urandom & $urandom;
        dp         = 8'($urandom & $urandom);
        digit_en   = 8'($urandom);
        brightness = 3'($urandom);
      end
      tick();
    end
    load = 1'b0;

    // Reset mid-frame with a pending load
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    brightness = 3'd7;
    wait_frame();
    repeat (8) tick();
    data = 32'h76543210; digit_en = 8'hFF; dp = 8'h00;
    load = 1'b1; tick(); load = 1'b0;
    repeat (11) tick();
    rst = 1'b1; tick();
    check("rstmid_an", AN, 8'hFF);
    check("rstmid_seg", SEG, 8'hFF);
    check("rstmid_fs", frame_start, 0);
    rst = 1'b0;
    #1;
    check("restart_fs", frame_start, 1);
    seen = 0;
    repeat (2 * ND) begin tick(); if (AN != 8'hFF) seen++; end
    check("pending_discarded", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
